alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execution stage directly downstream of the ALU control decoder.
- Consumes the 4-bit operation code, the two 32-bit operands and the shift amount.
- Produces a registered result, a zero flag and a one-cycle done pulse.
- Single-cycle ops finish in one clock. Shifts and multiply iterate under a small FSM, so the datapath stalls on busy_o.

Parameters:
DATA_WIDTH, 32, operand and result width
SHAMT_WIDTH, 5, shift-amount width; equals log2(DATA_WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
start_i  input  1  operation request, sampled only in IDLE
alu_operation_i  input  4  operation code from ALU control
a_data_i  input  DATA_WIDTH  operand A (rs)
b_data_i  input  DATA_WIDTH  operand B (rt or immediate)
shamt_i  input  SHAMT_WIDTH  shift amount
busy_o  output  1  high while an operation is in flight
done_o  output  1  one-cycle pulse; result_o valid from this cycle on
result_o  output  DATA_WIDTH  registered result, held until the next done
zero_o  output  1  high when result_o == 0, registered together with result_o

Behaviour:
- Reset (reset == 0, asynchronous): FSM goes to IDLE; busy_o = 0, done_o = 0, result_o = 0, zero_o = 1. Internal counters and accumulators clear.
- Operation codes:
  - 0000 AND: A & B
  - 0010 OR: A | B
  - 0011 ADD: A + B, wraps modulo 2^DATA_WIDTH, no overflow flag
  - 0001 SUB: A - B, wraps
  - 0100 LUI: {B[15:0], 16'h0000}
  - 0101 SLL: B << shamt, iterative
  - 0110 SRL: B >> shamt, logical, iterative
  - 0111 MUL: low DATA_WIDTH bits of A*B, unsigned shift-add, iterative
  - Any other code (including 1001): result 0, single-cycle.
- Operands and shamt are captured at acceptance. Later input changes do not affect an in-flight operation.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE, start_i = 1, single-cycle op: result_o and zero_o update on that edge; done_o = 1 the next cycle; stay IDLE. Latency 1 edge.
  - IDLE, start_i = 1, SLL/SRL: load B into the shift register and shamt into the counter; busy_o = 1; go to SHIFT.
  - IDLE, start_i = 1, MUL: load the multiplicand, the multiplier and a zeroed accumulator; set the counter to DATA_WIDTH; busy_o = 1; go to MUL.
  - SHIFT: while counter != 0, shift one bit per edge and decrement. When counter == 0, write result_o, pulse done_o, clear busy_o, return to IDLE. Latency = shamt + 1 edges; shamt = 0 gives latency 1 with the result equal to B.
  - MUL: each edge, if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right, and decrement. After DATA_WIDTH iterations, write result_o, pulse done_o, clear busy_o, return to IDLE. Latency = DATA_WIDTH + 1 edges.
- done_o is high exactly one cycle per accepted operation.
- start_i while busy_o = 1 is ignored; no queueing.
- Back-to-back: start_i in the same cycle as done_o is accepted, because the FSM is already IDLE.
- busy_o is combinational from state: high in SHIFT and MUL, low in IDLE.
- Reset mid-operation aborts immediately. No done_o is produced, and result_o returns to 0.

Test Plan:
- Reset asserted mid-MUL → busy_o = 0, done_o = 0, result_o = 0, zero_o = 1 immediately. After release, ADD with A = 5, B = 7 → result 12 after 1 edge, done pulse exactly 1 cycle.
- SUB with A = 3, B = 5 → result 0xFFFFFFFE. SUB with A = B = 0x1234 → result 0, zero_o = 1. LUI with B = 0x0000ABCD → 0xABCD0000.
- SLL with B = 0x00000001, shamt = 31 → 0x80000000, done at edge 32. SRL with B = 0x80000000, shamt = 0 → 0x80000000 at edge 1. start_i pulsed during SHIFT is ignored.
- MUL with A = 0xFFFF, B = 0x10001 → 0xFFFFFFFF, done at edge 33, busy_o high for 32 cycles. MUL with A = 0x80000000, B = 2 → 0, zero_o = 1.
- Undefined code 1001 with A = 5, B = 5 → result 0 after 1 edge. A new start_i in the done_o cycle is accepted, and its result appears on the following edge.

Source files
------------

// File: rtl/alu_multicycle.sv
// Execution stage behind the ALU control decoder. AND/OR/ADD/SUB/LUI finish in one edge.
// Shifts walk one bit per edge, and MUL runs a 32-step shift-add. busy_o stalls the datapath.
//
// state | meaning
// IDLE  | waiting for start_i; single-cycle ops complete here
// SHIFT | shifting the captured operand one bit per edge
// MUL   | shift-add multiply, one multiplier bit per edge
module alu_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_data_i,
  input  logic [DATA_WIDTH-1:0]  b_data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o
);

  localparam int CNT_W = SHAMT_WIDTH + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_LUI = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;   // shift register, or multiplicand during MUL
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  left_q, left_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] single_res;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [DATA_WIDTH-1:0] mul_nxt;
  logic                  is_shift;
  logic                  iter_op;

  always_comb begin
    single_res = '0;
    case (alu_operation_i)
      OP_AND:         single_res = a_data_i & b_data_i;
      OP_OR:          single_res = a_data_i | b_data_i;
      OP_ADD:         single_res = a_data_i + b_data_i;
      OP_SUB:         single_res = a_data_i - b_data_i;
      OP_LUI:         single_res = {b_data_i[15:0], {(DATA_WIDTH-16){1'b0}}};
      OP_SLL, OP_SRL: single_res = b_data_i;
      default:        single_res = '0;
    endcase
  end

  // A zero shift amount has nothing to iterate, so it completes like a single-cycle op.
  assign is_shift  = (alu_operation_i == OP_SLL) || (alu_operation_i == OP_SRL);
  assign iter_op   = (alu_operation_i == OP_MUL) || (is_shift && (shamt_i != '0));
  assign shift_nxt = left_q ? (opa_q << 1) : (opa_q >> 1);
  assign mul_nxt   = acc_q + (opb_q[0] ? opa_q : '0);

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (iter_op && is_shift) begin
            opa_d   = b_data_i;
            cnt_d   = {1'b0, shamt_i};
            left_d  = (alu_operation_i == OP_SLL);
            state_d = SHIFT;
          end else if (iter_op) begin
            opa_d   = a_data_i;
            opb_d   = b_data_i;
            acc_d   = '0;
            cnt_d   = CNT_W'(DATA_WIDTH);
            state_d = MUL;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        opa_d = shift_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = shift_nxt;
          zero_d   = (shift_nxt == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      MUL: begin
        acc_d = mul_nxt;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = mul_nxt;
          zero_d   = (mul_nxt == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases with literal expectations, then random traffic
// compared every cycle against a latency/result model derived from the operation rules.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [4:0]  sh;
  logic        busy, done, zero;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_multicycle #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(rst_n), .start_i(start), .alu_operation_i(op),
    .a_data_i(a), .b_data_i(b), .shamt_i(sh),
    .busy_o(busy), .done_o(done), .result_o(res), .zero_o(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] s);
    case (o)
      4'b0000: return x & y;
      4'b0010: return x | y;
      4'b0011: return x + y;
      4'b0001: return x - y;
      4'b0100: return y << 16;
      4'b0101: return y << s;
      4'b0110: return y >> s;
      4'b0111: return x * y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [4:0] s);
    if (o == 4'b0101 || o == 4'b0110) return (s == 0) ? 1 : int'(s) + 1;
    if (o == 4'b0111) return 33;
    return 1;
  endfunction

  // Model: m_rem counts edges still to go before an in-flight result lands.
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pend = 32'd0;
  logic        m_zero = 1'b1;
  logic        m_done = 1'b0;
  int          m_rem  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res <= 32'd0; m_zero <= 1'b1; m_done <= 1'b0; m_rem <= 0; m_pend <= 32'd0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_res <= m_pend; m_zero <= (m_pend == 0); m_done <= 1'b1;
        end
      end else if (start) begin
        if (ref_lat(op, sh) == 1) begin
          m_res  <= ref_res(op, a, b, sh);
          m_zero <= (ref_res(op, a, b, sh) == 0);
          m_done <= 1'b1;
        end else begin
          m_rem  <= ref_lat(op, sh) - 1;
          m_pend <= ref_res(op, a, b, sh);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc done",   {31'd0, done}, {31'd0, m_done});
      check("cyc busy",   {31'd0, busy}, {31'd0, (m_rem != 0)});
      check("cyc result", res, m_res);
      check("cyc zero",   {31'd0, zero}, {31'd0, m_zero});
    end
  end

  task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] s, input logic [31:0] exp_res,
                       input int exp_lat, input int exp_busy, input bit poke);
    int edges;
    int busy_cnt;
    start = 1'b1; op = o; a = x; b = y; sh = s;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sh = 5'($urandom);
    edges = 1;
    busy_cnt = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      if (poke && edges == 3) begin
        start = 1'b1; op = 4'b0011;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check({name, " latency"}, 32'(edges), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({name, " result"}, res, exp_res);
    check({name, " zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; sh = 5'd0;
    #1 rst_n = 1'b0;
    #2;
    check("reset result", res, 32'd0);
    check("reset zero", {31'd0, zero}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op("add pre", 4'b0011, 32'd9, 32'd4, 5'd0, 32'd13, 1, 0, 1'b0);
    start = 1'b1; op = 4'b0111; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul busy", {31'd0, busy}, 32'd0);
    check("midmul done", {31'd0, done}, 32'd0);
    check("midmul result", res, 32'd0);
    check("midmul zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add", 4'b0011, 32'd5, 32'd7, 5'd0, 32'd12, 1, 0, 1'b0);
    @(negedge clk);
    check("add done width", {31'd0, done}, 32'd0);
    do_op("sub neg", 4'b0001, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1, 0, 1'b0);
    do_op("sub eq", 4'b0001, 32'h1234, 32'h1234, 5'd0, 32'd0, 1, 0, 1'b0);
    do_op("lui", 4'b0100, 32'd0, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1, 0, 1'b0);
    do_op("sll31", 4'b0101, 32'd0, 32'h1, 5'd31, 32'h8000_0000, 32, 31, 1'b1);
    do_op("srl0", 4'b0110, 32'd0, 32'h8000_0000, 5'd0, 32'h8000_0000, 1, 0, 1'b0);
    do_op("srl4", 4'b0110, 32'd0, 32'hF000_0000, 5'd4, 32'h0F00_0000, 5, 4, 1'b0);
    do_op("mul", 4'b0111, 32'hFFFF, 32'h10001, 5'd0, 32'hFFFF_FFFF, 33, 32, 1'b0);
    do_op("mul ovf", 4'b0111, 32'h8000_0000, 32'd2, 5'd0, 32'd0, 33, 32, 1'b0);
    do_op("undef", 4'b1001, 32'd5, 32'd5, 5'd0, 32'd0, 1, 0, 1'b0);
    start = 1'b1; op = 4'b0011; a = 32'd10; b = 32'd20;
    @(negedge clk);
    start = 1'b0;
    check("b2b done", {31'd0, done}, 32'd1);
    check("b2b result", res, 32'd30);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 3) == 0;
      op    = ($urandom % 10 == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
      a     = $urandom;
      b     = ($urandom % 4 == 0) ? a : $urandom;
      sh    = ($urandom % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
